// File: rtl/gray_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_seq_decoder
// Purpose  : Gray-to-binary decoder with sequence tracking. It locks onto a
//            Gray count that increments cleanly and flags wraps and sequence
//            breaks. The optional error counter is enabled by the macro
//            GRAY_DEC_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module gray_seq_decoder #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             locked,
    output logic             wrap,
    output logic             seq_err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       C_LOCK_CNT = 4'(LOCK_CNT);
    localparam logic [WIDTH-1:0] C_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [3:0]       r_good_cnt;
    logic [WIDTH-1:0] r_ref;
    logic             r_bin_valid;
    logic             r_locked;
    logic             r_wrap;
    logic             r_seq_err;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_next;
    logic             w_correct;
    logic [3:0]       w_good_inc;

    // Each binary bit is the XOR of all Gray bits at or above its position.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bin
            assign w_bin[i] = ^(gray_in >> i);
        end
    endgenerate

    assign w_next     = r_ref + C_ONE;
    assign w_correct  = (w_bin == w_next);
    assign w_good_inc = r_good_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_SEARCH;
            r_good_cnt  <= 4'd0;
            r_ref       <= '0;
            r_bin_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_wrap      <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_bin_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_seq_err   <= 1'b0;
            if (in_valid) begin
                r_ref       <= w_bin;
                r_bin_valid <= 1'b1;
                case (r_state)
                    S_SEARCH: begin
                        r_good_cnt <= 4'd0;
                        r_state    <= S_TRACK;
                    end
                    S_TRACK: begin
                        if (w_correct) begin
                            r_good_cnt <= w_good_inc;
                            if (w_good_inc == C_LOCK_CNT) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_good_cnt <= 4'd0;
                        end
                    end
                    S_LOCKED: begin
                        if (w_correct) begin
                            r_wrap <= (w_bin == '0);
                        end else begin
                            r_seq_err  <= 1'b1;
                            r_good_cnt <= 4'd0;
                            r_state    <= S_TRACK;
                            r_locked   <= 1'b0;
                        end
                    end
                    default: begin
                        r_good_cnt <= 4'd0;
                        r_state    <= S_SEARCH;
                        r_locked   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bin_out   = r_ref;
    assign bin_valid = r_bin_valid;
    assign locked    = r_locked;
    assign wrap      = r_wrap;
    assign seq_err   = r_seq_err;

`ifdef GRAY_DEC_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    logic       w_break;

    // Counts on the same edge that raises seq_err.
    assign w_break = in_valid && (r_state == S_LOCKED) && !w_correct;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_break && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_seq_decoder
// Purpose  : Randomised self-checking bench for gray_seq_decoder against a
//            streak-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_seq_decoder;

    localparam int W   = 3;
    localparam int L   = 2;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] bin_out;
    logic         bin_valid;
    logic         locked;
    logic         wrap;
    logic         seq_err;
    logic [7:0]   err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a stream locks once it has seen L consecutive +1 steps since
    // its last acquisition or break.
    bit     m_have_ref;
    int     m_ref;
    int     m_streak;
    int     m_errs;
    logic [W-1:0] exp_bin;
    logic   exp_bv, exp_locked, exp_wrap, exp_err;

    logic [W+11:0] obs;
    logic [W+11:0] exp_vec;

    assign obs = {bin_out, bin_valid, locked, wrap, seq_err, err_cnt};

    gray_seq_decoder #(.WIDTH(W), .LOCK_CNT(L)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .gray_in  (gray_in),
        .bin_out  (bin_out),
        .bin_valid(bin_valid),
        .locked   (locked),
        .wrap     (wrap),
        .seq_err  (seq_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input bit r, input bit v, input int b);
        bit was_locked;
        bit good;
        int exp_cnt;
        @(negedge clk);
        reset    = r;
        in_valid = v;
        gray_in  = W'(b ^ (b >> 1));
        @(posedge clk);
        exp_bv   = 1'b0;
        exp_wrap = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            m_have_ref = 0;
            m_ref      = 0;
            m_streak   = 0;
            m_errs     = 0;
        end else if (v) begin
            exp_bv = 1'b1;
            if (!m_have_ref) begin
                m_have_ref = 1;
                m_streak   = 0;
            end else begin
                was_locked = (m_streak >= L);
                good       = (b == (m_ref + 1) % MOD);
                if (good) begin
                    m_streak = (m_streak >= L) ? L : m_streak + 1;
                    if (was_locked && b == 0) exp_wrap = 1'b1;
                end else begin
                    if (was_locked) begin
                        exp_err = 1'b1;
                        m_errs++;
                    end
                    m_streak = 0;
                end
            end
            m_ref = b;
        end
        exp_bin    = W'(m_ref);
        exp_locked = m_have_ref && (m_streak >= L);
`ifdef GRAY_DEC_ERR_CNT_EN
        exp_cnt = (m_errs > 255) ? 255 : m_errs;
`else
        exp_cnt = 0;
`endif
        exp_vec = {exp_bin, exp_bv, exp_locked, exp_wrap, exp_err, 8'(exp_cnt)};
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        n_checks++;
        if (obs !== {(W+12){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, {(W+12){1'b0}});
        end
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i);
            n_checks++;
            if (obs !== exp_vec || bin_out !== W'(i)) begin
                n_fail++;
                $display("FAIL lock_seq[%0d]: got %h want %h", i, obs, exp_vec);
            end
            if (i == 2) begin
                n_checks++;
                if (locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lock_after_third: got locked=%b want 1", locked);
                end
            end
        end
    endtask

    task automatic test_wrap();
        for (int b = 4; b <= 9; b++) begin
            step(0, 1, b % MOD);
            n_checks++;
            if (obs !== exp_vec || wrap !== ((b % MOD) == 0) || seq_err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h want %h", b % MOD, obs, exp_vec);
            end
        end
    endtask

    task automatic test_seq_break();
        int seq[6] = '{0, 1, 2, 4, 5, 6};
        step(1, 0, 0);
        foreach (seq[i]) begin
            step(0, 1, seq[i]);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL seq_break[%0d]: got %h want %h", i, obs, exp_vec);
            end
            if (i == 3) begin
                n_checks++;
                if (seq_err !== 1'b1 || locked !== 1'b0 || bin_out !== W'(4)) begin
                    n_fail++;
                    $display("FAIL break_pulse: got err=%b locked=%b bin=%0d want 1 0 4",
                             seq_err, locked, bin_out);
                end
            end
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: got locked=%b want 1", locked);
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, $urandom_range(0, MOD - 1));
            n_checks++;
            if (obs !== exp_vec || bin_valid || wrap || seq_err || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL gap[%0d]: got %h want %h", i, obs, exp_vec);
            end
        end
        step(0, 1, (m_ref + 1) % MOD);
        n_checks++;
        if (obs !== exp_vec || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_resume: got %h want %h", obs, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit r = ($urandom_range(0, 49) == 0);
            bit v = ($urandom_range(0, 3) != 0);
            int b = ($urandom_range(0, 9) < 8) ? (m_ref + 1) % MOD
                                               : int'($urandom_range(0, MOD - 1));
            step(r, v, b);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec);
            end
        end
    endtask

    task automatic test_err_cnt();
        int exp_final;
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, i);
        for (int k = 0; k < 300; k++) begin
            step(0, 1, (m_ref + 2) % MOD);
            for (int j = 0; j < L; j++) step(0, 1, (m_ref + 1) % MOD);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++;
                $display("FAIL err_loop[%0d]: got %h want %h", k, obs, exp_vec);
            end
        end
`ifdef GRAY_DEC_ERR_CNT_EN
        exp_final = 255;
`else
        exp_final = 0;
`endif
        n_checks++;
        if (err_cnt !== 8'(exp_final)) begin
            n_fail++;
            $display("FAIL err_cnt_sat: got %0d want %0d", err_cnt, exp_final);
        end
    endtask

    task automatic test_reset_priority();
        step(1, 1, 5);
        n_checks++;
        if (obs !== {(W+12){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_priority: got %h want 0", obs);
        end
        // A fresh SEARCH needs three samples before locking.
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, i);
            n_checks++;
            if (obs !== exp_vec || locked !== (i == 3)) begin
                n_fail++;
                $display("FAIL relock_after_reset[%0d]: got %h want %h", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        m_have_ref = 0;
        m_ref      = 0;
        m_streak   = 0;
        m_errs     = 0;
        test_reset();
        test_lock();
        test_wrap();
        test_seq_break();
        test_gap();
        test_random();
        test_err_cnt();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_seq_decoder.md
GRAY_SEQ_DECODER -- requirements
Module: gray_seq_decoder

Interface
REQ-001 Parameter WIDTH, default 3: Gray code width in bits (2..8).
REQ-002 Parameter LOCK_CNT, default 2: consecutive correct increments required to lock (1..15).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  gray_in carries a sample this cycle.
REQ-006 gray_in  input  WIDTH  Gray-coded count from the upstream Gray counter.
REQ-007 bin_out  output  WIDTH  registered binary equivalent of the last accepted sample.
REQ-008 bin_valid  output  1  one-cycle pulse: bin_out updated.
REQ-009 locked  output  1  high while the state machine is in LOCKED.
REQ-010 wrap  output  1  one-cycle pulse: a locked sequence returned to zero.
REQ-011 seq_err  output  1  one-cycle pulse: the sequence broke while locked.
REQ-012 err_cnt  output  8  saturating count of seq_err pulses (see Configuration).

Function
REQ-013 Conversion SHALL be bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1] XOR g[i] for i<WIDTH-1.
REQ-014 Latency SHALL be 1 cycle: sample accepted at edge N gives bin_out and bin_valid=1 after edge N.
REQ-015 Cycles with in_valid=0 SHALL be ignored: no state, counter, or reference change; bin_valid, wrap and seq_err are 0.
REQ-016 The block SHALL hold a reference ref = binary of the last accepted sample; a sample is correct when its binary equals (ref+1) mod 2^WIDTH.
REQ-017 A repeated value (binary equals ref) SHALL count as incorrect.
REQ-018 States SHALL be SEARCH, TRACK and LOCKED.
REQ-019 SEARCH, valid sample: load ref; good_cnt=0; go to TRACK.
REQ-020 TRACK, correct sample: good_cnt+1; if the new value equals LOCK_CNT, go to LOCKED.
REQ-021 TRACK, incorrect sample: good_cnt=0; load ref from the sample; stay in TRACK; no seq_err.
REQ-022 LOCKED, correct sample: stay in LOCKED.
REQ-023 LOCKED, incorrect sample: seq_err=1 for one cycle; load ref; good_cnt=0; go to TRACK; locked falls on the same edge.
REQ-024 wrap SHALL pulse only in LOCKED, on a correct sample decoding to 0, i.e. the transition from 2^WIDTH-1 to 0.
REQ-025 locked SHALL be registered and equal to (state==LOCKED).
REQ-026 ref SHALL always load from every accepted sample, so bin_out equals ref.

Reset
REQ-027 Reset SHALL force state=SEARCH, good_cnt=0, ref=0, bin_out=0, bin_valid=0, locked=0, wrap=0, seq_err=0, err_cnt=0.
REQ-028 Reset SHALL take priority over in_valid in the same cycle; the sample is discarded.
REQ-029 Reset asserted mid-sequence in any state SHALL fully abandon lock; relocking requires a fresh SEARCH->TRACK->LOCKED pass.

Configuration
REQ-030 Macro GRAY_DEC_ERR_CNT_EN defined: err_cnt SHALL increment on each seq_err pulse and saturate at 255; only reset clears it.
REQ-031 Macro GRAY_DEC_ERR_CNT_EN undefined: err_cnt port SHALL remain, tied to constant 0; no counter logic is synthesized.

Verification (WIDTH=3, LOCK_CNT=2)
REQ-032 Reset, then valid gray 000,001,011,010 on consecutive cycles -> bin_out 0,1,2,3 each one cycle later; locked=1 after the third sample.
REQ-033 Locked, then gray 100 (bin 7) followed by 000 -> wrap=1 for exactly one cycle with bin_out=0; seq_err stays 0.
REQ-034 Locked at bin 2 (011), then gray 110 (bin 4) -> seq_err=1 for one cycle, locked=0, bin_out=4; then 111 and 101 -> locked=1 again.
REQ-035 Locked, in_valid low for 5 cycles, then resume with the correct next value -> no bin_valid, wrap or seq_err pulses during the gap; locked stays 1.
REQ-036 With GRAY_DEC_ERR_CNT_EN defined, force 300 breaks (each followed by relock) -> err_cnt=255; assert reset concurrently with a valid sample -> all outputs 0, state SEARCH.
